// File: rtl/shift_sequencer_if.sv
// Command and shift-register control bundle for shift_sequencer.
// The master side issues commands and returns the register output;
// the slave side is the sequencer driving the register controls.
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic             cmd_ld;
   logic [AMT_W-1:0] cmd_amt;
   logic [WIDTH-1:0] cmd_data;
   logic             fill_bit;
   logic [WIDTH-1:0] r_in;
   logic [1:0]       sr_select;
   logic [WIDTH-1:0] sr_a;
   logic             sr_i_left;
   logic             sr_i_right;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output cmd_valid, cmd_op, cmd_ld, cmd_amt, cmd_data, fill_bit, r_in,
      input  cmd_ready, sr_select, sr_a, sr_i_left, sr_i_right, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ld, cmd_amt, cmd_data, fill_bit, r_in,
      output cmd_ready, sr_select, sr_a, sr_i_left, sr_i_right, busy, done, err
   );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a 16-bit universal shift register.
// Takes one command at a time, optionally loads the register, then walks
// it through N single-bit shift/rotate steps and pulses done.
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input logic              clk,
   input logic              rst,
   shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
   localparam logic [2:0] OP_ASR = 3'b110;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LOAD  = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_RIGHT = 2'b11;

   state_t           state;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] amt_q;
   logic [WIDTH-1:0] data_q;
   logic             fill_q;
   logic [AMT_W-1:0] cnt;
   logic [1:0]       sel_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             i_left;
   logic             i_right;

   function automatic logic op_legal(input logic [2:0] op);
      return (op != 3'b001) && (op != 3'b111);
   endfunction

   // Left-moving ops use select 10, everything else that shifts uses 11.
   function automatic logic [1:0] shift_sel(input logic [2:0] op);
      return ((op == OP_SHL) || (op == OP_ROL)) ? SEL_LEFT : SEL_RIGHT;
   endfunction

   function automatic logic will_shift(input logic [2:0] op, input logic [AMT_W-1:0] amt);
      return (amt != '0) && (op != OP_NOP);
   endfunction

   // Sequencer FSM: captures a command, steps LOAD/SHIFT and emits registered controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         amt_q   <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         cnt     <= '0;
         sel_q   <= SEL_HOLD;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (bus.cmd_valid) begin
                  op_q    <= bus.cmd_op;
                  amt_q   <= bus.cmd_amt;
                  data_q  <= bus.cmd_data;
                  fill_q  <= bus.fill_bit;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (!op_legal(bus.cmd_op)) begin
                     state  <= DONE;
                     sel_q  <= SEL_HOLD;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else if (bus.cmd_ld) begin
                     state <= LOAD;
                     sel_q <= SEL_LOAD;
                  end else if (will_shift(bus.cmd_op, bus.cmd_amt)) begin
                     state <= SHIFT;
                     sel_q <= shift_sel(bus.cmd_op);
                     cnt   <= bus.cmd_amt;
                  end else begin
                     state  <= DONE;
                     sel_q  <= SEL_HOLD;
                     done_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (will_shift(op_q, amt_q)) begin
                  state <= SHIFT;
                  sel_q <= shift_sel(op_q);
                  cnt   <= amt_q;
               end else begin
                  state  <= DONE;
                  sel_q  <= SEL_HOLD;
                  done_q <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == AMT_W'(1)) begin
                  state  <= DONE;
                  sel_q  <= SEL_HOLD;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt - AMT_W'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               sel_q   <= SEL_HOLD;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   // Serial fill bits follow the live register value so rotates and ASR see the current bits.
   always_comb begin
      i_left  = 1'b0;
      i_right = 1'b0;
      if (state == SHIFT) begin
         case (op_q)
            OP_SHL:  i_right = fill_q;
            OP_ROL:  i_right = bus.r_in[WIDTH-1];
            OP_SHR:  i_left  = fill_q;
            OP_ROR:  i_left  = bus.r_in[0];
            OP_ASR:  i_left  = bus.r_in[WIDTH-1];
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready  = ready_q;
   assign bus.sr_select  = sel_q;
   assign bus.sr_a       = data_q;
   assign bus.sr_i_left  = i_left;
   assign bus.sr_i_right = i_right;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the universal shift register around the
// DUT, queues expected results per accepted command and checks them at done.
module tb_shift_sequencer;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
   localparam logic [2:0] OP_ASR = 3'b110;

   typedef struct {
      logic [15:0] r;
      logic        err;
      int          lat;
      int          loads;
      int          shifts;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] r_reg = '0;
   logic [15:0] model_r = '0;
   exp_t        sb[$];
   int          n_vec = 0;
   int          n_bad = 0;

   shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus();

   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.r_in = r_reg;

   // Clock generator.
   always #5 clk = ~clk;

   // Behavioural universal shift register driven by the sequencer; not reset.
   always @(posedge clk) begin
      case (bus.sr_select)
         2'b01:   r_reg <= bus.sr_a;
         2'b10:   r_reg <= {r_reg[14:0], bus.sr_i_right};
         2'b11:   r_reg <= {bus.sr_i_left, r_reg[15:1]};
         default: r_reg <= r_reg;
      endcase
   end

   // Closed-form result of n single-bit steps of op applied to v.
   function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] v,
                                              input int n, input logic fill);
      int unsigned x;
      int unsigned res;
      int          s;
      x   = 32'(v);
      res = x;
      case (op)
         OP_SHL: res = (x << n) | (fill ? ((32'd1 << n) - 32'd1) : 32'd0);
         OP_SHR: res = (x >> n) | (fill ? (32'hFFFF & ~(32'hFFFF >> n)) : 32'd0);
         OP_ROL: res = (x << n) | (x >> (16 - n));
         OP_ROR: res = (x >> n) | (x << (16 - n));
         OP_ASR: begin
            s   = 32'(signed'(v));
            res = 32'(s >>> n);
         end
         default: res = x;
      endcase
      return 16'(res);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outcome of the command currently on the bus, pushed at acceptance.
   task automatic push_expect();
      exp_t        e;
      logic [2:0]  op;
      logic [15:0] v;
      int          n;
      op = bus.cmd_op;
      if (op == 3'b001 || op == 3'b111) begin
         e.r = model_r; e.err = 1'b1; e.lat = 1; e.loads = 0; e.shifts = 0;
      end else begin
         v        = bus.cmd_ld ? bus.cmd_data : model_r;
         n        = (op != OP_NOP) ? int'(bus.cmd_amt) : 0;
         e.r      = ref_result(op, v, n, bus.fill_bit);
         e.err    = 1'b0;
         e.loads  = int'(bus.cmd_ld);
         e.shifts = n;
         e.lat    = int'(bus.cmd_ld) + n + 1;
      end
      model_r = e.r;
      sb.push_back(e);
   endtask

   task automatic randomize_fields();
      bus.cmd_op   = 3'($urandom_range(0, 7));
      bus.cmd_ld   = 1'($urandom_range(0, 1));
      bus.cmd_amt  = 4'($urandom_range(0, 15));
      bus.cmd_data = 16'($urandom);
      bus.fill_bit = 1'($urandom_range(0, 1));
   endtask

   // Presents a command and waits for its acceptance; optionally scrambles fields while waiting.
   task automatic applyStimulus(input logic [2:0] op, input logic ld, input logic [3:0] amt,
                                input logic [15:0] data, input logic fill,
                                input bit keep_valid, input bit scramble);
      bit got;
      got = 0;
      @(posedge clk); #1;
      bus.cmd_op    = op;
      bus.cmd_ld    = ld;
      bus.cmd_amt   = amt;
      bus.cmd_data  = data;
      bus.fill_bit  = fill;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            push_expect();
            got = 1;
         end else begin
            @(posedge clk); #1;
            if (scramble) randomize_fields();
         end
      end
      if (!got) begin
         n_vec++; n_bad++;
         $display("[TB] FAIL accept_timeout: got no cmd_ready, expected acceptance within 200 cycles");
      end
      if (!keep_valid) begin
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && bus.cmd_ready) ok = 1;
      end
      if (!ok) begin
         n_vec++; n_bad++;
         $display("[TB] FAIL idle_timeout: got %0d pending results, expected 0", sb.size());
      end
   endtask

   // Monitor: tracks each accepted command, counts register activity and checks at done.
   initial begin : monitor
      int   cyc;
      int   acc_cyc;
      int   loads;
      int   shifts;
      bit   in_cmd;
      exp_t e;
      cyc = 0; acc_cyc = 0; loads = 0; shifts = 0; in_cmd = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            in_cmd = 0;
         end else begin
            if (in_cmd) begin
               if (bus.sr_select == 2'b01) loads++;
               if (bus.sr_select[1])       shifts++;
            end
            if (bus.done) begin
               if (in_cmd && sb.size() > 0) begin
                  e = sb.pop_front();
                  checkOutput("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                  checkOutput("err",     32'(bus.err),       32'(e.err));
                  checkOutput("r_final", 32'(r_reg),         32'(e.r));
                  checkOutput("loads",   32'(loads),         32'(e.loads));
                  checkOutput("shifts",  32'(shifts),        32'(e.shifts));
               end else begin
                  n_vec++; n_bad++;
                  $display("[TB] FAIL unexpected_done: got done with %0d pending, expected none", sb.size());
               end
               in_cmd = 0;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
               in_cmd  = 1;
               acc_cyc = cyc;
               loads   = 0;
               shifts  = 0;
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized commands.
   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_ld    = 1'b0;
      bus.cmd_amt   = '0;
      bus.cmd_data  = '0;
      bus.fill_bit  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready",  32'(bus.cmd_ready), 32'd1);
      checkOutput("rst_busy",   32'(bus.busy),      32'd0);
      checkOutput("rst_done",   32'(bus.done),      32'd0);
      checkOutput("rst_select", 32'(bus.sr_select), 32'd0);
      checkOutput("rst_sr_a",   32'(bus.sr_a),      32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      applyStimulus(OP_ROL, 1'b1, 4'd4, 16'h1234, 1'b0, 0, 0);
      wait_idle();
      checkOutput("rol_value", 32'(r_reg), 32'h2341);

      applyStimulus(OP_SHR, 1'b1, 4'd3, 16'h00F0, 1'b1, 1, 0);
      applyStimulus(OP_ASR, 1'b1, 4'd2, 16'h8004, 1'b0, 0, 0);
      wait_idle();
      checkOutput("asr_value", 32'(r_reg), 32'hE001);

      applyStimulus(OP_NOP, 1'b1, 4'd7, 16'hABCD, 1'b0, 0, 0);
      applyStimulus(OP_SHL, 1'b0, 4'd0, 16'h5555, 1'b1, 0, 0);
      wait_idle();
      checkOutput("amt0_value", 32'(r_reg), 32'hABCD);
      applyStimulus(OP_NOP, 1'b1, 4'd0, 16'hABCD, 1'b0, 0, 0);
      applyStimulus(OP_SHL, 1'b0, 4'd15, 16'h0000, 1'b1, 0, 0);
      wait_idle();

      applyStimulus(3'b111, 1'b1, 4'd5, 16'h1111, 1'b1, 0, 0);
      applyStimulus(3'b001, 1'b0, 4'd5, 16'h2222, 1'b0, 0, 0);
      wait_idle();

      // Reset after one load and three shift cycles.
      applyStimulus(OP_SHL, 1'b1, 4'd8, 16'h0001, 1'b0, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_select", 32'(bus.sr_select),  32'd0);
      checkOutput("abort_ready",  32'(bus.cmd_ready),  32'd1);
      checkOutput("abort_busy",   32'(bus.busy),       32'd0);
      checkOutput("abort_done",   32'(bus.done),       32'd0);
      checkOutput("abort_err",    32'(bus.err),        32'd0);
      checkOutput("abort_sr_a",   32'(bus.sr_a),       32'd0);
      checkOutput("abort_iright", 32'(bus.sr_i_right), 32'd0);
      if (sb.size() > 0) void'(sb.pop_front());
      model_r = ref_result(OP_SHL, 16'h0001, 3, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("abort_r_held", 32'(r_reg), 32'(model_r));
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(OP_ROR, 1'b0, 4'd2, 16'h0000, 1'b0, 0, 0);
      wait_idle();

      // cmd_valid held while fields keep changing during a ROR 5.
      applyStimulus(OP_ROR, 1'b1, 4'd5, 16'h00C3, 1'b0, 1, 0);
      applyStimulus(OP_SHL, 1'b0, 4'd1, 16'h0000, 1'b0, 0, 1);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), 16'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
